// File: rtl/ifetch_rom_req.sv
// Instruction-fetch requester: issues sequential word reads to a single-cycle ROM and
// buffers each {pc, instruction} response in a small FIFO toward decode.
module ifetch_rom_req #(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        rom_rx_valid,
   output logic [31:0] rom_rx_addr,
   input  logic        rom_tx_valid,
   input  logic [31:0] rom_tx_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned SumW = CntW + 1;

   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     pc_shadow_q;
   logic            drop_q;
   logic [CntW-1:0] count_q, count_d;
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic            rx_valid_d;
   logic [31:0]     rx_addr_d;

   logic [31:0]     pc_mem   [FIFO_DEPTH];
   logic [31:0]     inst_mem [FIFO_DEPTH];

   logic            resp_live, push, pop, issue;
   logic [SumW-1:0] demand;

   always_comb begin
      resp_live = rom_tx_valid & ~drop_q;
      push      = resp_live & ~redirect_valid;
      pop       = if_valid & if_ready & ~redirect_valid;
      // Pops are deliberately not credited so a full FIFO can never be overrun.
      demand    = SumW'(count_q) + SumW'(rom_rx_valid) + SumW'(resp_live);
      issue     = ~redirect_valid && (demand < SumW'(FIFO_DEPTH));
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rx_valid_d = 1'b0;
      rx_addr_d  = rom_rx_addr;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~32'd3;
      end else if (issue) begin
         rx_valid_d = 1'b1;
         rx_addr_d  = fetch_pc_q;
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
   end

   always_comb begin
      count_d = count_q;
      if (redirect_valid) begin
         count_d = '0;
      end else if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rom_rx_valid <= 1'b0;
         rom_rx_addr  <= '0;
         fetch_pc_q   <= RESET_PC;
         pc_shadow_q  <= '0;
         drop_q       <= 1'b0;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         rom_rx_valid <= rx_valid_d;
         rom_rx_addr  <= rx_addr_d;
         fetch_pc_q   <= fetch_pc_d;
         pc_shadow_q  <= rom_rx_addr;
         // A request already on the ROM port at redirect time returns stale data next cycle.
         drop_q       <= redirect_valid & rom_rx_valid;
         count_q      <= count_d;
         if (redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= pc_shadow_q;
         inst_mem[wr_ptr_q] <= rom_tx_data;
      end
   end

   always_comb begin
      if_valid = (count_q != '0);
      if_pc    = if_valid ? pc_mem[rd_ptr_q]   : '0;
      if_inst  = if_valid ? inst_mem[rd_ptr_q] : '0;
   end

endmodule

// File: tb/tb_ifetch_rom_req.sv
// Bench for ifetch_rom_req: acts as the ROM (data = addr ^ A5A5_A5A5) and checks
// against a queue-based model of the fetch buffer.
module tb_ifetch_rom_req;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] KEY    = 32'hA5A5_A5A5;
   localparam int          DEPTH  = 4;

   logic        clk, rstn;
   logic        rom_rx_valid, rom_tx_valid, redirect_valid, if_valid, if_ready;
   logic [31:0] rom_rx_addr, rom_tx_data, redirect_pc, if_pc, if_inst;

   ifetch_rom_req #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .rom_rx_valid   (rom_rx_valid),
      .rom_rx_addr    (rom_rx_addr),
      .rom_tx_valid   (rom_tx_valid),
      .rom_tx_data    (rom_tx_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_inst        (if_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic        m_rx_v, m_drop;
   logic [31:0] m_rx_a, m_pc, m_resp_pc;
   logic [63:0] mq[$];
   int          m_overflow = 0;

   function automatic logic m_iv();
      return mq.size() != 0;
   endfunction

   function automatic logic [31:0] m_head_pc();
      logic [63:0] h;
      if (mq.size() == 0) return 32'h0;
      h = mq[0];
      return h[63:32];
   endfunction

   function automatic logic [31:0] m_head_inst();
      logic [63:0] h;
      if (mq.size() == 0) return 32'h0;
      h = mq[0];
      return h[31:0];
   endfunction

   task automatic model_reset();
      mq.delete();
      m_rx_v    = 1'b0;
      m_rx_a    = 32'h0;
      m_pc      = RST_PC;
      m_drop    = 1'b0;
      m_resp_pc = 32'h0;
   endtask

   // Advance model and ROM by one clock; returns at posedge + 1.
   task automatic tick();
      int          occ;
      logic        push, pop, issue, s_v;
      logic [31:0] s_a, old_a;
      s_v  = rom_rx_valid;
      s_a  = rom_rx_addr;
      occ  = mq.size();
      push = rom_tx_valid && !m_drop;
      pop  = (occ != 0) && if_ready;
      if (!rstn) begin
         model_reset();
      end else if (redirect_valid) begin
         mq.delete();
         m_drop    = m_rx_v;
         m_rx_v    = 1'b0;
         m_pc      = {redirect_pc[31:2], 2'b00};
         m_resp_pc = m_rx_a;
      end else begin
         if (push && occ >= DEPTH) m_overflow++;
         issue = (occ + int'(m_rx_v) + int'(push)) < DEPTH;
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back({m_resp_pc, m_resp_pc ^ KEY});
         old_a     = m_rx_a;
         m_resp_pc = old_a;
         m_drop    = 1'b0;
         if (issue) begin
            m_rx_v = 1'b1;
            m_rx_a = m_pc;
            m_pc   = m_pc + 32'd4;
         end else begin
            m_rx_v = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      rom_tx_valid = rstn ? s_v : 1'b0;
      rom_tx_data  = s_a ^ KEY;
   endtask

   task automatic test_reset();
      rstn = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      rom_tx_valid = 1'b0; rom_tx_data = 32'h0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      total++; if (rom_rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rom_rx_valid); end
      total++; if (rom_rx_addr !== 32'h0) begin bad++; $display("FAIL reset_rx_addr got=%h want=0", rom_rx_addr); end
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_if_valid got=%b want=0", if_valid); end
      total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_if_pc got=%h want=0", if_pc); end
      total++; if (if_inst !== 32'h0) begin bad++; $display("FAIL reset_if_inst got=%h want=0", if_inst); end
   endtask

   task automatic test_stream();
      logic [31:0] exp;
      if_ready = 1'b1;
      rstn = 1'b1;
      tick();
      total++; if (rom_rx_valid !== 1'b1 || rom_rx_addr !== RST_PC) begin
         bad++; $display("FAIL stream_first_req got=%b/%h want=1/%h", rom_rx_valid, rom_rx_addr, RST_PC);
      end
      tick();
      tick();
      for (int i = 0; i < 32; i++) begin
         exp = RST_PC + 32'(4 * i);
         total++; if (if_valid !== 1'b1 || if_pc !== exp || if_inst !== (exp ^ KEY)) begin
            bad++; $display("FAIL stream_head[%0d] got=%b/%h/%h want=1/%h/%h", i, if_valid, if_pc,
                            if_inst, exp, exp ^ KEY);
         end
         total++; if (rom_rx_valid !== 1'b1 || rom_rx_addr !== m_rx_a) begin
            bad++; $display("FAIL stream_req[%0d] got=%b/%h want=1/%h", i, rom_rx_valid, rom_rx_addr, m_rx_a);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int          nreq, npop;
      logic [31:0] pops[8];
      rstn = 1'b0; rom_tx_valid = 1'b0; if_ready = 1'b0;
      model_reset();
      tick();
      rstn = 1'b1;
      nreq = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (rom_rx_valid) nreq++;
         if (c >= 3) begin
            total++; if (if_valid !== 1'b1 || if_pc !== RST_PC) begin
               bad++; $display("FAIL bp_hold[%0d] got=%b/%h want=1/%h", c, if_valid, if_pc, RST_PC);
            end
         end
      end
      total++; if (nreq !== 4) begin bad++; $display("FAIL bp_req_count got=%0d want=4", nreq); end
      if_ready = 1'b1;
      npop = 0;
      for (int c = 0; c < 60 && npop < 8; c++) begin
         if (if_valid) begin pops[npop] = if_pc; npop++; end
         tick();
      end
      total++; if (npop !== 8) begin bad++; $display("FAIL bp_drain_timeout got=%0d want=8", npop); end
      for (int i = 0; i < npop; i++) begin
         total++; if (pops[i] !== RST_PC + 32'(4 * i)) begin
            bad++; $display("FAIL bp_drain_order[%0d] got=%h want=%h", i, pops[i], RST_PC + 32'(4 * i));
         end
      end
   endtask

   task automatic test_redirect();
      repeat (5) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_1003;
      tick();
      redirect_valid = 1'b0;
      total++; if (if_valid !== 1'b0 || rom_rx_valid !== 1'b0) begin
         bad++; $display("FAIL redir_t1 got=%b/%b want=0/0", if_valid, rom_rx_valid);
      end
      tick();
      total++; if (rom_rx_valid !== 1'b1 || rom_rx_addr !== 32'h0000_1000) begin
         bad++; $display("FAIL redir_req got=%b/%h want=1/00001000", rom_rx_valid, rom_rx_addr);
      end
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_t2_valid got=%b want=0", if_valid); end
      tick();
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_t3_valid got=%b want=0", if_valid); end
      tick();
      total++; if (if_valid !== 1'b1 || if_pc !== 32'h1000 || if_inst !== (32'h1000 ^ KEY)) begin
         bad++; $display("FAIL redir_first got=%b/%h/%h want=1/00001000/%h", if_valid, if_pc, if_inst,
                         32'h1000 ^ KEY);
      end
   endtask

   task automatic test_multi_redirect();
      int          npop;
      logic [31:0] exp;
      redirect_valid = 1'b1;
      redirect_pc = 32'h100; tick();
      redirect_pc = 32'h200; tick();
      redirect_pc = 32'h300; tick();
      redirect_valid = 1'b0;
      npop = 0;
      for (int c = 0; c < 40 && npop < 8; c++) begin
         total++; if (if_valid !== m_iv() || if_pc !== m_head_pc()) begin
            bad++; $display("FAIL multi_model[%0d] got=%b/%h want=%b/%h", c, if_valid, if_pc, m_iv(), m_head_pc());
         end
         if (if_valid) begin
            exp = 32'h300 + 32'(4 * npop);
            total++; if (if_pc !== exp) begin
               bad++; $display("FAIL multi_pc[%0d] got=%h want=%h", npop, if_pc, exp);
            end
            npop++;
         end
         tick();
      end
      total++; if (npop !== 8) begin bad++; $display("FAIL multi_timeout got=%0d want=8", npop); end
   endtask

   task automatic test_redirect_pop();
      logic found;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (if_valid && if_ready && rom_tx_valid) found = 1'b1;
         else tick();
      end
      total++; if (!found) begin bad++; $display("FAIL rpop_setup got=0 want=1"); end
      redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
      tick();
      redirect_valid = 1'b0;
      total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rpop_flush got=%b want=0", if_valid); end
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         if (if_valid) found = 1'b1;
         else tick();
      end
      total++; if (!found || if_pc !== 32'h2000) begin
         bad++; $display("FAIL rpop_first got=%b/%h want=1/00002000", found, if_pc);
      end
   endtask

   task automatic test_wrap_reset();
      int          n;
      logic [31:0] addrs[3];
      logic [31:0] exp[3];
      exp[0] = 32'hFFFF_FFF8; exp[1] = 32'hFFFF_FFFC; exp[2] = 32'h0000_0000;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 10 && n < 3; c++) begin
         tick();
         if (rom_rx_valid) begin addrs[n] = rom_rx_addr; n++; end
      end
      total++; if (n !== 3) begin bad++; $display("FAIL wrap_timeout got=%0d want=3", n); end
      for (int i = 0; i < n; i++) begin
         total++; if (addrs[i] !== exp[i]) begin
            bad++; $display("FAIL wrap_addr[%0d] got=%h want=%h", i, addrs[i], exp[i]);
         end
      end
      repeat (3) tick();
      rstn = 1'b0;
      #1;
      total++; if (rom_rx_valid !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0) begin
         bad++; $display("FAIL async_reset got=%b/%b/%h want=0/0/0", rom_rx_valid, if_valid, if_pc);
      end
      model_reset();
      rom_tx_valid = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      total++; if (rom_rx_valid !== 1'b1 || rom_rx_addr !== RST_PC) begin
         bad++; $display("FAIL restart got=%b/%h want=1/%h", rom_rx_valid, rom_rx_addr, RST_PC);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if_ready       = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc    = $urandom();
         tick();
         total++; if (rom_rx_valid !== m_rx_v || rom_rx_addr !== m_rx_a) begin
            bad++; $display("FAIL rand_req[%0d] got=%b/%h want=%b/%h", c, rom_rx_valid, rom_rx_addr, m_rx_v, m_rx_a);
         end
         total++; if (if_valid !== m_iv() || if_pc !== m_head_pc() || if_inst !== m_head_inst()) begin
            bad++; $display("FAIL rand_head[%0d] got=%b/%h/%h want=%b/%h/%h", c, if_valid, if_pc, if_inst,
                            m_iv(), m_head_pc(), m_head_inst());
         end
      end
      redirect_valid = 1'b0;
      total++; if (m_overflow !== 0) begin bad++; $display("FAIL fifo_overflow got=%0d want=0", m_overflow); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_multi_redirect();
      test_redirect_pop();
      test_wrap_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
